// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader.
//   boot_state_e : loader FSM state encoding (also driven on state_dbg)
//   SYNC_BYTE    : byte that starts (or restarts) a load
//   LEN_BYTES    : number of little-endian length bytes after the sync byte
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } boot_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_BYTES = 4;

endpackage

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives A5, a 32-bit little-endian length, the payload
// and an 8-bit additive checksum, writing each payload byte into RAM while
// holding the CPU in reset until a good image has been loaded.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   rx_data    : received UART byte
//   rx_valid   : one-cycle strobe qualifying rx_data (may assert every cycle)
//   wr_en      : one-cycle RAM byte-write strobe, one cycle after the byte
//   wr_addr    : word-aligned RAM byte address
//   wr_data    : payload byte replicated on all four lanes
//   wr_strb    : one-hot byte-lane enable, zero when wr_en is low
//   cpu_hold   : registered, high in every state except DONE
//   done       : image loaded and checksum good
//   error      : last load attempt failed
//   state_dbg  : current FSM state encoding
//
// Handshake: rx_valid is a strobe with no back-pressure; every cycle it is
// high, rx_data is consumed. wr_en is likewise a strobe with no ready.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE      = 32'h80000000,
  parameter logic [31:0] MAX_LEN        = 32'h800000,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [2:0]  state_dbg
);

  localparam int          CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LEN_LAST = 2'(LEN_BYTES - 1);

  boot_state_e   state, state_nx;
  logic [31:0]   len_q;
  logic [31:0]   off_q;
  logic [7:0]    csum_q;
  logic [1:0]    len_cnt;
  logic [CW-1:0] tmo_cnt;

  logic [31:0]   len_full;
  logic          active;
  logic          tmo_hit;
  logic          enter_len;
  logic          data_wr;

  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    // Length bytes shift in from the top so the first byte lands in [7:0].
    len_full = {rx_data, len_q[31:8]};
    active   = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
    // A byte arriving on the expiry cycle wins over the timeout.
    tmo_hit  = active && !rx_valid && (tmo_cnt == TMO_LAST);
    data_wr  = (state == ST_DATA) && rx_valid;

    case (state)
      ST_IDLE, ST_ERROR: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_nx = ST_LEN;
      end
      ST_LEN: begin
        if (rx_valid && len_cnt == LEN_LAST) begin
          if (len_full != 32'd0 && len_full <= MAX_LEN) state_nx = ST_DATA;
          else                                          state_nx = ST_ERROR;
        end
      end
      ST_DATA: begin
        if (rx_valid && (off_q + 32'd1 == len_q)) state_nx = ST_CSUM;
      end
      ST_CSUM: begin
        if (rx_valid) state_nx = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE: state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase

    if (tmo_hit) state_nx = ST_ERROR;

    enter_len = (state_nx == ST_LEN) && (state != ST_LEN);
  end

  // State and status flags; status is decoded from the next state so the
  // outputs are plain flops with no decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_nx;
      cpu_hold <= (state_nx != ST_DONE);
      done     <= (state_nx == ST_DONE);
      error    <= (state_nx == ST_ERROR);
    end
  end

  // Length, offset, checksum and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= 32'd0;
      off_q   <= 32'd0;
      csum_q  <= 8'd0;
      len_cnt <= 2'd0;
      tmo_cnt <= '0;
    end else begin
      if (enter_len) begin
        len_q   <= 32'd0;
        off_q   <= 32'd0;
        csum_q  <= 8'd0;
        len_cnt <= 2'd0;
      end else if (rx_valid && state == ST_LEN) begin
        len_q   <= len_full;
        len_cnt <= len_cnt + 2'd1;
      end else if (data_wr) begin
        off_q   <= off_q + 32'd1;
        csum_q  <= csum_q + rx_data;
      end

      if (rx_valid || enter_len) tmo_cnt <= '0;
      else if (active)           tmo_cnt <= tmo_cnt + CW'(1);
      else                       tmo_cnt <= '0;
    end
  end

  // RAM write port: exactly one cycle after each payload byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= LOAD_BASE;
      wr_data <= 32'd0;
      wr_strb <= 4'd0;
    end else begin
      wr_en <= data_wr;
      if (data_wr) begin
        wr_addr <= LOAD_BASE + {off_q[31:2], 2'b00};
        wr_data <= {4{rx_data}};
        wr_strb <= 4'b0001 << off_q[1:0];
      end else begin
        wr_strb <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  localparam logic [31:0] LOAD_BASE = 32'h80000000;
  localparam logic [31:0] MAX_LEN   = 32'h800000;
  localparam int          TMO       = 40;

  localparam logic [2:0] S_IDLE = 3'd0, S_LEN = 3'd1, S_DONE = 3'd4, S_ERROR = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // expected write: {addr, data, strb}
  logic [67:0] exp_q[$];
  logic [7:0]  pay_q[$];
  int          run_len = 0;
  int          max_run = 0;

  uart_boot_loader #(
    .LOAD_BASE(LOAD_BASE),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_strb(wr_strb),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- write scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_write observed=%h/%h/%h expected=none", wr_addr, wr_data, wr_strb);
        end else begin
          logic [67:0] e;
          e = exp_q.pop_front();
          assert ({wr_addr, wr_data, wr_strb} === e) else begin
            errors++;
            $error("FAIL write observed=%h/%h/%h expected=%h/%h/%h",
                   wr_addr, wr_data, wr_strb, e[67:36], e[35:4], e[3:0]);
          end
        end
      end else begin
        run_len = 0;
        if (wr_strb !== 4'd0) begin
          checks++;
          errors++;
          $error("FAIL strb_idle observed=%h expected=0", wr_strb);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at a negedge with rx_valid low.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_len = 0;
    max_run = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},    {29'd0, state_dbg}, {29'd0, S_IDLE});
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"},     {31'd0, done},     32'd0);
    check({tag, "_error"},    {31'd0, error},    32'd0);
    check({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
    check({tag, "_wr_strb"},  {28'd0, wr_strb},  32'd0);
    check({tag, "_wr_data"},  wr_data,           32'd0);
    check({tag, "_wr_addr"},  wr_addr,           LOAD_BASE);
  endtask

  // Reference model: expected RAM writes for a payload, from the address rule.
  task automatic model_writes();
    for (int i = 0; i < pay_q.size(); i++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = LOAD_BASE + 32'(i - (i % 4));
      s = 4'(1 << (i % 4));
      exp_q.push_back({a, {4{pay_q[i]}}, s});
    end
  endtask

  function automatic logic [7:0] model_sum();
    int s = 0;
    foreach (pay_q[i]) s += pay_q[i];
    return 8'(s % 256);
  endfunction

  // Sends a full load: sync, length, payload (from pay_q), checksum.
  // gap < 0 picks a random gap per byte.
  task automatic run_load(input string tag, input logic [31:0] len, input bit corrupt,
                          input int gap);
    logic [7:0] cs;
    bit len_ok;
    len_ok = (len >= 1) && (len <= MAX_LEN);
    send_byte(8'hA5, 1);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1);
    if (len_ok) begin
      model_writes();
      foreach (pay_q[i]) send_byte(pay_q[i], (gap < 0) ? $urandom_range(0, 3) : gap);
      cs = model_sum();
      if (corrupt) cs = cs ^ 8'(1 << $urandom_range(0, 7));
      send_byte(cs, 0);
    end
    repeat (3) @(negedge clk);
    if (len_ok && !corrupt) begin
      check({tag, "_state"},    {29'd0, state_dbg}, {29'd0, S_DONE});
      check({tag, "_done"},     {31'd0, done},     32'd1);
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
      check({tag, "_error"},    {31'd0, error},    32'd0);
    end else begin
      check({tag, "_state"},    {29'd0, state_dbg}, {29'd0, S_ERROR});
      check({tag, "_done"},     {31'd0, done},     32'd0);
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
      check({tag, "_error"},    {31'd0, error},    32'd1);
    end
    check({tag, "_writes_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    check_reset_values("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_rel");

    // Golden image, checksum 0xFF.
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    check("golden_sum", {24'd0, model_sum()}, 32'hFF);
    run_load("golden", 32'd5, 1'b0, 1);

    // DONE ignores further bytes, including sync.
    send_byte(8'hA5, 2);
    check("done_sticky", {29'd0, state_dbg}, {29'd0, S_DONE});

    // Bad checksum, then restart via sync.
    do_reset();
    run_load("badcs", 32'd5, 1'b1, 1);
    send_byte(8'hA5, 1);
    check("restart_state", {29'd0, state_dbg}, {29'd0, S_LEN});
    check("restart_error", {31'd0, error}, 32'd0);

    // Zero length and oversize length.
    do_reset();
    pay_q.delete();
    run_load("len0", 32'd0, 1'b0, 1);
    do_reset();
    run_load("lenbig", MAX_LEN + 32'd1, 1'b0, 1);
    do_reset();
    pay_q = '{8'h5A};
    run_load("len1", 32'd1, 1'b0, 0);

    // IDLE ignores non-sync bytes, then LEN times out.
    do_reset();
    send_byte(8'h00, 1);
    send_byte(8'h7F, 1);
    check("idle_ignore", {29'd0, state_dbg}, {29'd0, S_IDLE});
    send_byte(8'hA5, 0);
    check("sync_len", {29'd0, state_dbg}, {29'd0, S_LEN});
    repeat (TMO - 1) @(negedge clk);
    check("tmo_before", {29'd0, state_dbg}, {29'd0, S_LEN});
    @(negedge clk);
    check("tmo_state", {29'd0, state_dbg}, {29'd0, S_ERROR});
    check("tmo_error", {31'd0, error}, 32'd1);

    // A byte on the would-be expiry cycle keeps the load alive.
    do_reset();
    send_byte(8'hA5, TMO - 1);
    send_byte(8'h02, TMO - 1);
    check("tmo_byte_wins", {29'd0, state_dbg}, {29'd0, S_LEN});

    // Eight back-to-back payload bytes.
    do_reset();
    pay_q.delete();
    for (int i = 0; i < 8; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    run_load("b2b", 32'd8, 1'b0, 0);
    check("b2b_run", max_run, 32'd8);

    // Reset after the third payload byte.
    do_reset();
    pay_q = '{8'hC1, 8'hC2, 8'hC3};
    model_writes();
    send_byte(8'hA5, 1);
    send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    foreach (pay_q[i]) send_byte(pay_q[i], 0);
    #2 rst = 1'b1;
    send_byte(8'hC4, 0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    check("midrst_writes", exp_q.size(), 32'd0);
    exp_q.delete();

    // Randomized loads.
    for (int t = 0; t < 8; t++) begin
      int n;
      bit bad;
      do_reset();
      n = $urandom_range(1, 14);
      bad = ($urandom_range(0, 3) == 0);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
      run_load($sformatf("rnd%0d", t), 32'(n), bad, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
